// File: rtl/muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl_if
// Purpose  : Request, multiplier/divider unit and result signals of muldiv_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_ctrl_if;
    logic [1:0]       req_valid;
    logic [1:0][1:0]  req_op;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic             stall_in;
    logic             flush;
    logic             mul_start;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic             mul_done;
    logic [63:0]      mul_c;
    logic             div_start;
    logic [31:0]      div_a;
    logic [31:0]      div_b;
    logic             div_done;
    logic [63:0]      div_c;
    logic             busy;
    logic             res_valid;
    logic             res_slot;
    logic [63:0]      hilo;

    modport slave (
        input  req_valid, req_op, req_a, req_b, stall_in, flush,
        input  mul_done, mul_c, div_done, div_c,
        output mul_start, mul_a, mul_b, div_start, div_a, div_b,
        output busy, res_valid, res_slot, hilo
    );

    modport master (
        output req_valid, req_op, req_a, req_b, stall_in, flush,
        output mul_done, mul_c, div_done, div_c,
        input  mul_start, mul_a, mul_b, div_start, div_a, div_b,
        input  busy, res_valid, res_slot, hilo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Purpose  : Two-slot MULT/MULTU/DIV/DIVU sequencer with sign handling around
//            unsigned multiplier/divider units. Optional MULDIV_DIV0_FAST_EN
//            short-circuits division by zero without starting the divider.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl (
    input  wire logic      clk,
    input  wire logic      reset,
    muldiv_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        slot_q, slot_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic [31:0] mag_a_q, mag_a_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic        start_q, start_d;
    logic [63:0] hilo_q, hilo_d;

    // Slot 1 is the older instruction and always wins arbitration.
    logic        w_sel_slot;
    logic [1:0]  w_sel_op;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_b;
    logic        w_sel_neg_a;
    logic        w_sel_neg_b;

    assign w_sel_slot  = bus.req_valid[1];
    assign w_sel_op    = bus.req_op[w_sel_slot];
    assign w_sel_a     = bus.req_a[w_sel_slot];
    assign w_sel_b     = bus.req_b[w_sel_slot];
    assign w_sel_neg_a = ~w_sel_op[0] & w_sel_a[31];
    assign w_sel_neg_b = ~w_sel_op[0] & w_sel_b[31];

    logic        w_res_neg;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_res_neg  = ~op_q[0] & (neg_a_q ^ neg_b_q);
    assign w_prod_fix = w_res_neg ? (64'd0 - bus.mul_c) : bus.mul_c;
    assign w_quo_fix  = w_res_neg ? (32'd0 - bus.div_c[31:0]) : bus.div_c[31:0];
    assign w_rem_fix  = neg_a_q ? (32'd0 - bus.div_c[63:32]) : bus.div_c[63:32];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        slot_d  = slot_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        start_d = 1'b0;
        hilo_d  = hilo_q;

        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    op_d    = w_sel_op;
                    slot_d  = w_sel_slot;
                    neg_a_d = w_sel_neg_a;
                    neg_b_d = w_sel_neg_b;
                    mag_a_d = w_sel_neg_a ? (32'd0 - w_sel_a) : w_sel_a;
                    mag_b_d = w_sel_neg_b ? (32'd0 - w_sel_b) : w_sel_b;
                    start_d = 1'b1;
                    state_d = w_sel_op[1] ? DIV : MUL;
`ifdef MULDIV_DIV0_FAST_EN
                    if (w_sel_op[1] && (w_sel_b == 32'd0)) begin
                        start_d = 1'b0;
                        state_d = DONE;
                        hilo_d  = {w_sel_a, 32'hFFFF_FFFF};
                    end
`endif
                end
            end
            MUL: begin
                if (bus.mul_done) begin
                    state_d = DONE;
                    hilo_d  = w_prod_fix;
                end
            end
            DIV: begin
                if (bus.div_done) begin
                    state_d = DONE;
                    hilo_d  = {w_rem_fix, w_quo_fix};
                end
            end
            DONE: begin
                if (!bus.stall_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush kills everything, including an accept in the same cycle.
        if (bus.flush) begin
            state_d = IDLE;
            start_d = 1'b0;
            hilo_d  = 64'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 2'd0;
            slot_q  <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            mag_a_q <= 32'd0;
            mag_b_q <= 32'd0;
            start_q <= 1'b0;
            hilo_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            slot_q  <= slot_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            start_q <= start_d;
            hilo_q  <= hilo_d;
        end
    end

    assign bus.mul_start = start_q & (state_q == MUL) & ~op_q[1];
    assign bus.div_start = start_q & (state_q == DIV) &  op_q[1];
    assign bus.mul_a     = (state_q == MUL) ? mag_a_q : 32'd0;
    assign bus.mul_b     = (state_q == MUL) ? mag_b_q : 32'd0;
    assign bus.div_a     = (state_q == DIV) ? mag_a_q : 32'd0;
    assign bus.div_b     = (state_q == DIV) ? mag_b_q : 32'd0;
    assign bus.busy      = ((state_q == IDLE) && (|bus.req_valid)) ||
                           (state_q == MUL) || (state_q == DIV);
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_slot  = slot_q;
    assign bus.hilo      = hilo_q;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_ctrl
// Purpose  : Scoreboard bench for muldiv_ctrl with behavioural unit models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;
`ifdef MULDIV_DIV0_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_ctrl_if bus ();
    muldiv_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct { logic is_div; logic [31:0] ma; logic [31:0] mb; } op_t;
    typedef struct { logic slot; logic [63:0] hilo; } res_t;

    op_t  opq[$];
    res_t resq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   forced_lat = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mag(input logic [31:0] v, input bit sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction

    // Reference result straight from signed/unsigned arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint q;
        longint r;
        logic [63:0] ua = {32'd0, a};
        logic [63:0] ub = {32'd0, b};
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'd0)
                    return FAST ? {a, 32'hFFFF_FFFF} : {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Multiplier/divider unit model; also checks issued operands against the queue.
    initial begin
        op_t e;
        logic is_div;
        logic [31:0] ca, cb;
        int lat;
        bus.mul_done = 1'b0; bus.mul_c = 64'd0;
        bus.div_done = 1'b0; bus.div_c = 64'd0;
        forever begin
            @(negedge clk);
            if (bus.mul_start || bus.div_start) begin
                is_div = bus.div_start;
                chk("start_onehot", 64'(bus.mul_start & bus.div_start), 64'd0);
                ca = is_div ? bus.div_a : bus.mul_a;
                cb = is_div ? bus.div_b : bus.mul_b;
                if (opq.size() == 0) begin
                    chk("unexpected_start", 64'd1, 64'd0);
                end else begin
                    e = opq.pop_front();
                    chk("unit_select", 64'(is_div), 64'(e.is_div));
                    chk("operand_a", 64'(ca), 64'(e.ma));
                    chk("operand_b", 64'(cb), 64'(e.mb));
                end
                lat = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 4));
                repeat (lat) @(negedge clk);
                if (is_div) begin
                    bus.div_c    = (cb == 32'd0) ? {ca, 32'hFFFF_FFFF} : {ca % cb, ca / cb};
                    bus.div_done = 1'b1;
                end else begin
                    bus.mul_c    = {32'd0, ca} * {32'd0, cb};
                    bus.mul_done = 1'b1;
                end
                // Junk done from the inactive unit must be ignored.
                if ($urandom_range(0, 2) == 0) begin
                    if (is_div) begin bus.mul_done = 1'b1; bus.mul_c = {$urandom, $urandom}; end
                    else        begin bus.div_done = 1'b1; bus.div_c = {$urandom, $urandom}; end
                end
                @(negedge clk);
                bus.mul_done = 1'b0;
                bus.div_done = 1'b0;
            end
        end
    end

    // Monitor: pops on each new result, checks hold while it stays valid.
    initial begin
        res_t r;
        logic prev_rv = 1'b0;
        logic [63:0] held_hilo = 64'd0;
        logic held_slot = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.res_valid && !prev_rv) begin
                if (resq.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    r = resq.pop_front();
                    chk("hilo", bus.hilo, r.hilo);
                    chk("res_slot", 64'(bus.res_slot), 64'(r.slot));
                end
            end else if (bus.res_valid && prev_rv) begin
                chk("hilo_hold", bus.hilo, held_hilo);
                chk("slot_hold", 64'(bus.res_slot), 64'(held_slot));
            end
            prev_rv   = bus.res_valid;
            held_hilo = bus.hilo;
            held_slot = bus.res_slot;
        end
    end

    task automatic run_txn(input logic [1:0] v, input logic [1:0][1:0] ops,
                           input logic [1:0][31:0] as, input logic [1:0][31:0] bs,
                           input int stall_cyc);
        logic w;
        logic [1:0] op;
        logic [31:0] a, b;
        bit fast, sgn;
        op_t e;
        res_t r;
        int cyc;
        w    = v[1];
        op   = ops[w];
        a    = as[w];
        b    = bs[w];
        sgn  = ~op[0];
        fast = FAST && op[1] && (b == 32'd0);
        @(negedge clk);
        bus.req_valid = v;
        bus.req_op    = ops;
        bus.req_a     = as;
        bus.req_b     = bs;
        bus.stall_in  = (stall_cyc > 0);
        if (!fast) begin
            e.is_div = op[1]; e.ma = mag(a, sgn); e.mb = mag(b, sgn);
            opq.push_back(e);
        end
        r.slot = w;
        r.hilo = ref_model(op, a, b);
        resq.push_back(r);
        #1 chk("busy_on_request", 64'(bus.busy), 64'd1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.req_a     = {$urandom, $urandom};
        bus.req_b     = {$urandom, $urandom};
        chk("mul_start_t1", 64'(bus.mul_start), 64'(!op[1]));
        chk("div_start_t1", 64'(bus.div_start), 64'(op[1] && !fast));
        if (!fast) begin
            @(negedge clk);
            chk("start_one_cycle", {62'd0, bus.mul_start, bus.div_start}, 64'd0);
        end
        cyc = 0;
        while (!bus.res_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.res_valid) begin
            chk("result_timeout", 64'd1, 64'd0);
            bus.stall_in = 1'b0;
            return;
        end
        chk("operands_zero_in_done", {bus.mul_a, bus.div_b}, 64'd0);
        chk("busy_in_done", 64'(bus.busy), 64'd0);
        repeat ((stall_cyc > 0) ? stall_cyc - 1 : 0) begin
            @(negedge clk);
            chk("stall_hold_valid", 64'(bus.res_valid), 64'd1);
        end
        // Stray request during the release cycle must not be accepted.
        bus.stall_in  = 1'b0;
        bus.req_valid = 2'(($urandom % 3) + 1);
        bus.req_op    = 4'($urandom);
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("released_valid", 64'(bus.res_valid), 64'd0);
        chk("no_accept_on_release", {61'd0, bus.busy, bus.mul_start, bus.div_start}, 64'd0);
    endtask

    // Kill an op mid-flight by flush (use_reset=0) or reset (use_reset=1).
    task automatic kill_test(input bit use_reset, input logic [1:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        op_t e;
        forced_lat = 4;
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.req_op    = {2'b00, op};
        bus.req_a     = {32'd0, a};
        bus.req_b     = {32'd0, b};
        e.is_div = op[1]; e.ma = mag(a, ~op[0]); e.mb = mag(b, ~op[0]);
        opq.push_back(e);
        @(negedge clk);
        bus.req_valid = 2'b00;
        forced_lat = -1;
        @(negedge clk);
        if (use_reset) reset = 1'b1; else bus.flush = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.flush = 1'b0;
        chk(use_reset ? "reset_valid" : "flush_valid", 64'(bus.res_valid), 64'd0);
        chk(use_reset ? "reset_hilo"  : "flush_hilo",  bus.hilo, 64'd0);
        chk(use_reset ? "reset_busy"  : "flush_busy",  64'(bus.busy), 64'd0);
        chk("killed_operands", {bus.div_a, bus.mul_a}, 64'd0);
        repeat (8) begin
            @(negedge clk);
            chk("late_done_ignored", 64'(bus.res_valid), 64'd0);
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.req_valid = 2'b00; bus.req_op = 4'd0;
        bus.req_a = 64'd0; bus.req_b = 64'd0;
        bus.stall_in = 1'b0; bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_hilo", bus.hilo, 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_starts", {62'd0, bus.mul_start, bus.div_start}, 64'd0);
        chk("rst_operands", {bus.mul_a, bus.div_a}, 64'd0);
        chk("rst_slot", 64'(bus.res_slot), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        forced_lat = 2;
        run_txn(2'b10, {2'b00, 2'b01}, {32'hFFFF_FFFD, 32'd9}, {32'd7, 32'd4}, 0);
        forced_lat = -1;
        run_txn(2'b11, {2'b01, 2'b11}, {32'd6, 32'd100}, {32'd5, 32'd3}, 0);
        run_txn(2'b01, {2'b00, 2'b10}, {32'd1, 32'hFFFF_FFF9}, {32'd1, 32'd2}, 3);
        run_txn(2'b01, {2'b00, 2'b11}, {32'd0, 32'd5}, {32'd0, 32'd0}, 0);
        run_txn(2'b10, {2'b10, 2'b00}, {32'hFFFF_FFFB, 32'd0}, {32'd0, 32'd0}, 1);
        run_txn(2'b10, {2'b00, 2'b00}, {32'h8000_0000, 32'd0}, {32'h8000_0000, 32'd0}, 0);
        run_txn(2'b01, {2'b00, 2'b10}, {32'd0, 32'h8000_0000}, {32'd0, 32'hFFFF_FFFF}, 2);
        kill_test(1'b0, 2'b10, 32'hFFFF_FFF0, 32'd3);
        kill_test(1'b1, 2'b00, 32'd12, 32'hFFFF_FFFE);

        for (int i = 0; i < 60; i++) begin
            run_txn(2'($urandom_range(1, 3)), 4'($urandom),
                    {rnd_operand(), rnd_operand()}, {rnd_operand(), rnd_operand()},
                    int'($urandom_range(0, 3)));
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", 64'(resq.size() + opq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
